// File: rtl/scan_harness.sv
// scan_harness
//
// Serial scan harness for bitstream-fuzzing minitests.
// - Deserialises a DIN_N-bit vector from a one-bit input stream.
// - Applies the vector to the region-of-interest (ROI) in a single update.
// - Waits CAP_DLY cycles for the ROI to settle.
// - Captures the DOUT_N-bit ROI response and serialises it out, MSB first.
//
// Optional feature macro: SCAN_HARNESS_PARITY_EN
//   When defined, one extra beat follows the captured vector on the serial
//   output. That beat is the even parity (XOR reduction) of the captured dout.
//
// Parameters
//   DIN_N    width of the vector driven to the ROI (>= 1)
//   DOUT_N   width of the vector captured from the ROI (>= 1)
//   CAP_DLY  cycles from ROI input update to capture (>= 1)
//
// Ports
//   clk     single clock; all state changes on its rising edge
//   rst     synchronous, active-high reset; abandons any frame in progress
//   di      serial input bit
//   di_vld  di is valid this cycle
//   di_rdy  harness accepts di; a bit is taken when di_vld && di_rdy
//   stb     early apply: a frame in LOAD ends now, using the bits received
//   do_bit  serial output bit, MSB of the captured vector first
//           (called "do" at system level; "do" is a reserved word in
//           SystemVerilog, so the port carries this name)
//   do_vld  do_bit is valid
//   do_rdy  downstream accepts do_bit; a beat completes when do_vld && do_rdy
//   din     registered vector driven to the ROI
//   dout    ROI response
//
// Every output comes straight from a register. No output has a
// combinational path from di_vld or do_rdy.
module scan_harness #(
    parameter int DIN_N   = 160,
    parameter int DOUT_N  = 160,
    parameter int CAP_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di,
    input  logic              di_vld,
    output logic              di_rdy,
    input  logic              stb,
    output logic              do_bit,
    output logic              do_vld,
    input  logic              do_rdy,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout
);

`ifdef SCAN_HARNESS_PARITY_EN
    localparam int PAR_N = 1;
`else
    localparam int PAR_N = 0;
`endif

    // The output shifter holds the captured vector, followed by the parity
    // bit when that feature is enabled. The shifter is unloaded MSB first.
    localparam int SHR_W  = DOUT_N + PAR_N;
    localparam int IN_W   = $clog2(DIN_N + 1);
    localparam int OUT_W  = $clog2(SHR_W + 1);
    localparam int WAIT_W = $clog2(CAP_DLY + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_APPLY,
        S_WAIT,
        S_CAPTURE,
        S_UNLOAD
    } state_t;

    state_t              state_reg;
    logic [DIN_N-1:0]    din_shr_reg;
    logic [DIN_N-1:0]    din_reg;
    logic [SHR_W-1:0]    dout_shr_reg;
    logic [IN_W-1:0]     in_cnt_reg;
    logic [OUT_W-1:0]    out_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic                di_rdy_reg;
    logic                do_vld_reg;

    // Shifting {din_shr, di} and keeping the low DIN_N bits gives a
    // left shift with di entering at the LSB. This form stays legal
    // when DIN_N == 1.
    logic [DIN_N:0]      din_shift_next;
    logic [SHR_W-1:0]    cap_word_next;
    logic                accept;
    logic                beat;

    assign din_shift_next = {din_shr_reg, di};
    assign accept         = di_vld && di_rdy_reg;
    assign beat           = do_vld_reg && do_rdy;

`ifdef SCAN_HARNESS_PARITY_EN
    assign cap_word_next = {dout, ^dout};
`else
    assign cap_word_next = dout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_LOAD;
            din_shr_reg  <= '0;
            din_reg      <= '0;
            dout_shr_reg <= '0;
            in_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            di_rdy_reg   <= 1'b1;
            do_vld_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    // An accepted bit is shifted in first. This also holds on
                    // the cycle where stb ends the frame early.
                    if (accept) begin
                        din_shr_reg <= din_shift_next[DIN_N-1:0];
                        in_cnt_reg  <= in_cnt_reg + IN_W'(1);
                    end
                    if (stb || (accept && in_cnt_reg == IN_W'(DIN_N - 1))) begin
                        state_reg  <= S_APPLY;
                        di_rdy_reg <= 1'b0;
                    end
                end

                S_APPLY: begin
                    // din_shr is not cleared here. A later short frame
                    // reuses the residual high bits.
                    din_reg      <= din_shr_reg;
                    in_cnt_reg   <= '0;
                    wait_cnt_reg <= '0;
                    state_reg    <= (CAP_DLY == 1) ? S_CAPTURE : S_WAIT;
                end

                S_WAIT: begin
                    // This state lasts CAP_DLY-1 cycles. It is only entered
                    // when CAP_DLY >= 2.
                    if (wait_cnt_reg == WAIT_W'(CAP_DLY - 2)) begin
                        state_reg <= S_CAPTURE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end

                S_CAPTURE: begin
                    dout_shr_reg <= cap_word_next;
                    out_cnt_reg  <= '0;
                    do_vld_reg   <= 1'b1;
                    state_reg    <= S_UNLOAD;
                end

                S_UNLOAD: begin
                    // The zero fill leaves the shifter at zero after the last
                    // beat. As a result, do_bit idles low outside UNLOAD.
                    if (beat) begin
                        dout_shr_reg <= dout_shr_reg << 1;
                        out_cnt_reg  <= out_cnt_reg + OUT_W'(1);
                        if (out_cnt_reg == OUT_W'(SHR_W - 1)) begin
                            state_reg  <= S_LOAD;
                            do_vld_reg <= 1'b0;
                            di_rdy_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg  <= S_LOAD;
                    di_rdy_reg <= 1'b1;
                    do_vld_reg <= 1'b0;
                end
            endcase
        end
    end

    assign di_rdy = di_rdy_reg;
    assign do_vld = do_vld_reg;
    assign do_bit = dout_shr_reg[SHR_W-1];
    assign din    = din_reg;

endmodule

// File: tb/tb_scan_harness.sv
// Testbench for scan_harness (DIN_N = DOUT_N = 8, CAP_DLY = 2).
//
// The ROI is modelled as dout = din ^ roi_key. The reference model works
// at frame level:
// - din_shr is tracked as the accepted bits shifted in.
// - din is expected to take that value at apply.
// - The serial output is expected to carry the ROI word MSB first, plus
//   the parity beat when SCAN_HARNESS_PARITY_EN is defined.
module tb_scan_harness;
    localparam int DIN_N   = 8;
    localparam int DOUT_N  = 8;
    localparam int CAP_DLY = 2;
`ifdef SCAN_HARNESS_PARITY_EN
    localparam int NB = DOUT_N + 1;
`else
    localparam int NB = DOUT_N;
`endif

    logic              clk;
    logic              rst;
    logic              di;
    logic              di_vld;
    logic              di_rdy;
    logic              stb;
    logic              do_bit;
    logic              do_vld;
    logic              do_rdy;
    logic [DIN_N-1:0]  din;
    logic [DOUT_N-1:0] dout;
    logic [DOUT_N-1:0] roi_key;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0] shr_m;
    logic [7:0] din_m;

    scan_harness #(
        .DIN_N   (DIN_N),
        .DOUT_N  (DOUT_N),
        .CAP_DLY (CAP_DLY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .di     (di),
        .di_vld (di_vld),
        .di_rdy (di_rdy),
        .stb    (stb),
        .do_bit (do_bit),
        .do_vld (do_vld),
        .do_rdy (do_rdy),
        .din    (din),
        .dout   (dout)
    );

    assign dout = din ^ roi_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge. Outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        di_vld = 1'b0;
        stb    = 1'b0;
        do_rdy = 1'b0;
        tick();
        rst   = 1'b0;
        shr_m = '0;
        din_m = '0;
        check("rst_din", din, 0);
        check("rst_vld", do_vld, 0);
        check("rst_rdy", di_rdy, 1);
        check("rst_do", do_bit, 0);
    endtask

    // Run one frame:
    // - n bits (MSB first from the low n bits of pat), optional stb on the
    //   last bit (or alone when n == 0).
    // - gap_mode inserts random idle cycles while loading.
    // - rdy_mode selects the do_rdy pattern: 0 = always ready,
    //   1 = repeating 1,0,0, 2 = random.
    // - abort_beat >= 0 pulses reset at that beat of the unload.
    task automatic frame(input int n, input bit use_stb, input logic [7:0] pat,
                         input int gap_mode, input int rdy_mode, input int abort_beat);
        logic [7:0] word;
        logic [8:0] exp_bits;
        logic       pv;
        logic       pb;
        bit         r;
        int         beats;
        int         guard;
        int         k;
        check("rdy_load", di_rdy, 1);
        for (int i = 0; i < n; i++) begin
            if (gap_mode != 0 && $urandom_range(0, 2) == 0) begin
                di_vld = 1'b0;
                di     = 1'($urandom);
                stb    = 1'b0;
                tick();
                check("rdy_gap", di_rdy, 1);
            end
            di     = pat[n-1-i];
            di_vld = 1'b1;
            stb    = use_stb && (i == n - 1);
            tick();
            shr_m = {shr_m[6:0], pat[n-1-i]};
        end
        if (n == 0) begin
            di_vld = 1'b0;
            stb    = 1'b1;
            tick();
        end
        // Now in the APPLY cycle. Inputs here must be ignored.
        di_vld = 1'($urandom);
        di     = 1'b1;
        stb    = 1'($urandom);
        check("din_hold", din, din_m);
        check("rdy_apply", di_rdy, 0);
        tick();
        din_m = shr_m;
        check("din_apply", din, din_m);
        word     = din_m ^ roi_key;
        exp_bits = {word, ^word};
        // WAIT + CAPTURE: do_vld is expected to stay low for CAP_DLY cycles.
        for (int j = 0; j < CAP_DLY; j++) begin
            check("vld_wait", do_vld, 0);
            check("rdy_wait", di_rdy, 0);
            di_vld = 1'($urandom);
            stb    = 1'($urandom);
            tick();
        end
        beats = 0;
        guard = 0;
        k     = 0;
        while (beats < NB && guard < 200) begin
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = (k % 3 == 0);
                default: r = 1'($urandom);
            endcase
            k++;
            do_rdy = r;
            pv     = do_vld;
            pb     = do_bit;
            check("vld_unload", pv, 1);
            check("rdy_unload", di_rdy, 0);
            if (r) check($sformatf("beat%0d", beats), pb, exp_bits[8-beats]);
            di_vld = 1'($urandom);
            di     = 1'b1;
            stb    = 1'($urandom);
            if (beats == abort_beat) begin
                do_reset();
                return;
            end
            tick();
            guard++;
            if (r) begin
                beats++;
            end else begin
                check("hold_vld", do_vld, pv);
                check("hold_do", do_bit, pb);
            end
        end
        check("unload_done", beats, NB);
        do_rdy = 1'b0;
        di_vld = 1'b0;
        stb    = 1'b0;
        check("vld_idle", do_vld, 0);
        check("rdy_idle", di_rdy, 1);
        check("do_idle", do_bit, 0);
    endtask

    initial begin
        int  n;
        bit  s;
        rst     = 1'b1;
        di      = 1'b0;
        di_vld  = 1'b0;
        stb     = 1'b0;
        do_rdy  = 1'b0;
        roi_key = '0;
        shr_m   = '0;
        din_m   = '0;
        tick();
        tick();
        check("reset_din", din, 0);
        check("reset_vld", do_vld, 0);
        check("reset_rdy", di_rdy, 1);
        check("reset_do", do_bit, 0);
        rst = 1'b0;
        tick();
        check("idle_rdy", di_rdy, 1);
        check("idle_vld", do_vld, 0);

        // Loopback of A5, continuous handshakes.
        frame(8, 1'b0, 8'hA5, 0, 0, -1);
        check("loop_din", din, 8'hA5);

        // Early stb after reset: two ones give din = 03.
        do_reset();
        frame(2, 1'b1, 8'h03, 0, 0, -1);
        check("stb_din", din, 8'h03);

        // Backpressure with do_rdy cycling 1,0,0.
        frame(8, 1'b0, 8'($urandom), 0, 1, -1);

        // stb with no bits: din_shr is reapplied unchanged.
        frame(0, 1'b1, 8'h00, 0, 0, -1);

        // Reset in the middle of LOAD after 4 bits.
        for (int i = 0; i < 4; i++) begin
            di     = 1'($urandom);
            di_vld = 1'b1;
            tick();
        end
        do_reset();
        frame(8, 1'b0, 8'($urandom), 0, 0, -1);

        // Reset during UNLOAD, then a fresh frame.
        frame(8, 1'b0, 8'($urandom), 0, 0, 3);
        frame(8, 1'b0, 8'($urandom), 1, 2, -1);

        // Captured 07: low three bits (and parity 1 when enabled).
        roi_key = '0;
        frame(8, 1'b0, 8'h07, 0, 0, -1);

        // Randomised frames.
        for (int f = 0; f < 30; f++) begin
            roi_key = 8'($urandom);
            n       = $urandom_range(0, 8);
            s       = (n < 8) ? 1'b1 : 1'($urandom);
            frame(n, s, 8'($urandom), 1, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_harness.md
# scan_harness

Parametrised serial scan harness for bitstream-fuzzing minitests: deserialises a DIN_N-bit input vector from a one-bit pin, applies it to the region-of-interest (ROI) in one update, waits a programmable settle time, captures the ROI's DOUT_N-bit response and serialises it back out. It replaces the fixed-width, externally strobed shifter in each minitest top. It adds self-counted framing, valid/ready handshakes on both serial sides, and a capture delay for registered ROI outputs.

## Interface
- DIN_N, 160: width of the parallel vector driven to the ROI; ≥1.
- DOUT_N, 160: width of the parallel vector captured from the ROI; ≥1.
- CAP_DLY, 2: cycles from ROI input update to capture; ≥1.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- di  input  1  serial input bit.
- di_vld  input  1  di is valid this cycle.
- di_rdy  output  1  harness accepts di; a bit is taken when di_vld && di_rdy.
- stb  input  1  early apply: frame in LOAD ends immediately, with the bits received so far.
- do  output  1  serial output bit, MSB of captured vector first.
- do_vld  output  1  do is valid.
- do_rdy  input  1  downstream accepts do; a beat completes when do_vld && do_rdy.
- din  output  DIN_N  registered vector to ROI.
- dout  input  DOUT_N  ROI response.

## Operation
- States: LOAD, APPLY, WAIT, CAPTURE, UNLOAD.
- Reset (any state, any cycle): state=LOAD, shift registers=0, din=0, bit/wait counters=0. di_rdy=1, do_vld=0, do=0 from the first cycle after rst deasserts. Any frame in progress is abandoned.
- LOAD: di_rdy=1.
  - On each accepted bit: din_shr <= {din_shr[DIN_N-2:0], di}, and the in-counter increments.
  - When the accepted bit brings the count to DIN_N, go to APPLY.
  - stb in LOAD goes to APPLY on the same edge. If a bit is also accepted that cycle, it is shifted in first.
  - stb with zero bits received still applies (din_shr unchanged).
- APPLY: one cycle. din <= din_shr, in-counter cleared, go to WAIT.
- WAIT: counts CAP_DLY-1 cycles, then goes to CAPTURE. With CAP_DLY=1, WAIT lasts zero cycles and APPLY goes directly to CAPTURE.
- CAPTURE: one cycle. dout_shr <= dout, out-counter cleared, go to UNLOAD.
- UNLOAD: do_vld=1 and do=dout_shr[DOUT_N-1].
  - On each completed beat: shift left with 0 fill, and the out-counter increments.
  - After beat DOUT_N completes, return to LOAD.
  - do_rdy low stalls the frame; do and do_vld are held stable.
- di_rdy=0 outside LOAD; di_vld there is ignored and no bit is consumed. stb outside LOAD is ignored.
- din_shr is not cleared between frames: a short (stb) frame reuses residual high bits.
- Counter widths: $clog2(max+1); no wrap occurs in legal operation.

## Timing
- Full frame: the last accepted bit at edge N gives din update at edge N+1 (APPLY). Capture samples dout at edge N+1+CAP_DLY.
- First do_vld appears in the cycle after the capture edge.
- Minimum frame period, with continuous handshakes: DIN_N + 1 + CAP_DLY + DOUT_N cycles.
- din is stable from APPLY until the next APPLY; the ROI may treat it as quasi-static.
- All outputs are registered; there is no combinational path from di_vld or do_rdy to any output.

## Configuration
- SCAN_HARNESS_PARITY_EN
  - Defined: UNLOAD emits DOUT_N+1 beats. The final beat is even parity (XOR reduction) of the captured dout, computed at CAPTURE. The minimum frame period grows by 1.
  - Undefined: exactly DOUT_N beats; no parity logic is present.

## Test plan
- Loopback, DIN_N=DOUT_N=8, CAP_DLY=2, dout=din, continuous handshakes. Shift 8'hA5 MSB first → din=8'hA5 one cycle after the 8th bit. Then 10100101 on do over 8 consecutive beats; di_rdy returns high after the 8th beat.
- Early stb: after reset, shift bits 1,1 and assert stb with the 2nd bit → din=8'h03 at APPLY, full UNLOAD of 8 beats follows.
- Backpressure: do_rdy toggled 1,0,0,1,… during UNLOAD → do/do_vld held during low cycles; all 8 bits delivered in order, none duplicated.
- Ignored input: di_vld=1 with di=1 throughout WAIT/UNLOAD → next frame's din_shr contains only bits accepted in LOAD.
- Mid-frame reset: assert rst for one cycle after 4 bits of LOAD, or during UNLOAD → next cycle: din=0, do_vld=0, di_rdy=1. A fresh 8-bit frame then completes normally.
- With SCAN_HARNESS_PARITY_EN, capture dout=8'h07 → 9 beats: 00000111 then 1.
